imem_responder: RTL and testbench

- Instruction-memory responder for the fetch stage, replacing the ideal single-cycle instruction memory.
- The fetch stage issues a PC-addressed read request; this block returns the 16-bit instruction after a fixed, parameterised latency using a valid/ready handshake.
- It supports fetch-side flush (branch redirect via PC_B) and a bench/program load port.
- It sits between fetch and the instruction storage, and its response feeds the IF/ID boundary.

---
 rtl/cpu_pkg.sv | 15 +
 rtl/imem_array.sv | 28 ++
 rtl/imem_responder.sv | 120 ++++++++++++
 tb/tb_imem_responder.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants and the instruction-memory responder state encoding.
package cpu_pkg;

  // Word returned in place of real data when a fetch address is bad.
  localparam logic [15:0] NOP_INSTR  = 16'h0800;
  localparam logic [15:0] HALT_INSTR = 16'h0000;

  // Responder FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } imem_state_e;

endpackage

// File: rtl/imem_array.sv
// DEPTH x 16 instruction storage.
// Writes come from the load port. A read is captured into cap_word on the
// edge that accepts a fetch. A same-edge load to that word is therefore not
// seen: the capture returns the old contents.
module imem_array #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          load_en,
  input  logic [AW-1:0] load_idx,
  input  logic [15:0]   load_data,
  input  logic          cap_en,
  input  logic [AW-1:0] cap_idx,
  output logic [15:0]   cap_word
);

  logic [15:0] mem [DEPTH];

  // Load write and capture-on-accept read
  // NOTE: storage and its capture register are deliberately left out of reset;
  // nothing consumes cap_word until a request has been captured.
  always_ff @(posedge clk) begin
    if (load_en) mem[load_idx] <= load_data;
    if (cap_en)  cap_word      <= mem[cap_idx];
  end

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder for the fetch stage.
// Accepts one PC-addressed request at a time and returns the 16-bit word
// LATENCY cycles later as a one-cycle rsp_valid pulse. A flush drops the
// request in WAIT, or suppresses the pulse in RESP. Bad addresses return
// NOP_INSTR with rsp_err set.
module imem_responder #(
  parameter int          DEPTH     = 256,
  parameter int          LATENCY   = 2,
  parameter logic [15:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic [15:0] req_addr,
  output logic        req_ready,
  input  logic        flush,
  output logic        rsp_valid,
  output logic [15:0] rsp_instr,
  output logic        rsp_err,
  output logic        busy,
  input  logic        load_en,
  input  logic [15:0] load_addr,
  input  logic [15:0] load_data
);
  import cpu_pkg::*;

  localparam int          AW       = $clog2(DEPTH);
  localparam int          CW       = (LATENCY > 2) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT = (LATENCY >= 2) ? CW'(LATENCY - 2) : '0;
  localparam logic [15:0] DEPTH_W  = 16'(DEPTH);

  localparam logic [1:0] S_IDLE = 2'(IDLE);
  localparam logic [1:0] S_WAIT = 2'(WAIT);
  localparam logic [1:0] S_RESP = 2'(RESP);

  // After an accept, go straight to RESP when there is no wait period.
  localparam logic [1:0] S_AFTER_ACCEPT = (LATENCY == 1) ? S_RESP : S_WAIT;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          accept;
  logic          req_err;
  logic          load_ok;
  logic          cap_err;
  logic [15:0]   cap_word;
  logic [15:0]   hold_instr;
  logic          hold_err;
  logic          unused_load_lsb;

  assign req_ready = (state == S_IDLE) || (state == S_RESP);
  assign accept    = req_valid && req_ready;
  assign busy      = (state != S_IDLE);
  assign rsp_valid = (state == S_RESP) && !flush;

  // Odd addresses and word indices at or beyond DEPTH are errors.
  // Addresses are never folded back into range.
  assign req_err = req_addr[0] || ({1'b0, req_addr[15:1]} >= DEPTH_W);
  assign load_ok = load_en && ({1'b0, load_addr[15:1]} < DEPTH_W);

  // Load addresses are byte addresses; the low bit is ignored.
  assign unused_load_lsb = load_addr[0];

  // In RESP the captured request is presented.
  // Elsewhere the outputs keep the last response.
  assign rsp_instr = (state == S_RESP) ? (cap_err ? NOP_INSTR : cap_word) : hold_instr;
  assign rsp_err   = (state == S_RESP) ? cap_err : hold_err;

  imem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk       (clk),
    .load_en   (load_ok),
    .load_idx  (load_addr[AW:1]),
    .load_data (load_data),
    .cap_en    (accept),
    .cap_idx   (req_addr[AW:1]),
    .cap_word  (cap_word)
  );

  // FSM, latency counter, error capture and held response outputs
  // NOTE: sequential state uses non-blocking assignments only. Every register
  // then samples pre-edge values, so the order of the statements does not matter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      cap_err    <= 1'b0;
      hold_instr <= 16'h0000;
      hold_err   <= 1'b0;
    end else begin
      if (accept) cap_err <= req_err;
      case (state)
        S_IDLE: begin
          if (accept) begin
            state <= S_AFTER_ACCEPT;
            cnt   <= CNT_INIT;
          end
        end
        S_WAIT: begin
          if (flush)            state <= S_IDLE;
          else if (cnt == '0)   state <= S_RESP;
          else                  cnt   <= cnt - CW'(1);
        end
        S_RESP: begin
          hold_instr <= cap_err ? NOP_INSTR : cap_word;
          hold_err   <= cap_err;
          if (accept) begin
            state <= S_AFTER_ACCEPT;
            cnt   <= CNT_INIT;
          end else begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// Directed self-checking bench for imem_responder.
// u_dut:  DEPTH=256, LATENCY=2
// u_dut1: DEPTH=4,   LATENCY=1
module tb_imem_responder;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        req_valid, flush, load_en;
  logic [15:0] req_addr, load_addr, load_data;
  logic        req_ready, rsp_valid, rsp_err, busy;
  logic [15:0] rsp_instr;

  logic        d1_req_valid, d1_flush, d1_load_en;
  logic [15:0] d1_req_addr, d1_load_addr, d1_load_data;
  logic        d1_req_ready, d1_rsp_valid, d1_rsp_err, d1_busy;
  logic [15:0] d1_rsp_instr;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  imem_responder #(.DEPTH(256), .LATENCY(2), .NOP_INSTR(16'h0800)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .flush     (flush),
    .rsp_valid (rsp_valid),
    .rsp_instr (rsp_instr),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data)
  );

  imem_responder #(.DEPTH(4), .LATENCY(1), .NOP_INSTR(16'h0800)) u_dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (d1_req_valid),
    .req_addr  (d1_req_addr),
    .req_ready (d1_req_ready),
    .flush     (d1_flush),
    .rsp_valid (d1_rsp_valid),
    .rsp_instr (d1_rsp_instr),
    .rsp_err   (d1_rsp_err),
    .busy      (d1_busy),
    .load_en   (d1_load_en),
    .load_addr (d1_load_addr),
    .load_data (d1_load_data)
  );

  task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    total++;
    assert (observed === expected)
      else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] addr, input logic [15:0] data);
    load_en = 1'b1; load_addr = addr; load_data = data;
    step();
    load_en = 1'b0;
  endtask

  task automatic d1_do_load(input logic [15:0] addr, input logic [15:0] data);
    d1_load_en = 1'b1; d1_load_addr = addr; d1_load_data = data;
    step();
    d1_load_en = 1'b0;
  endtask

  // Present a request for one cycle, then sample the LATENCY=2 response cycle.
  task automatic read2(input string tag, input logic [15:0] addr,
                       input logic [15:0] exp_instr, input logic exp_err);
    req_valid = 1'b1; req_addr = addr;
    step();
    req_valid = 1'b0;
    step();
    check({tag, "_valid"}, 16'(rsp_valid), 16'h1);
    check({tag, "_instr"}, rsp_instr, exp_instr);
    check({tag, "_err"},   16'(rsp_err), 16'(exp_err));
    step();
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_addr = '0; flush = 1'b0;
    load_en = 1'b0; load_addr = '0; load_data = '0;
    d1_req_valid = 1'b0; d1_req_addr = '0; d1_flush = 1'b0;
    d1_load_en = 1'b0; d1_load_addr = '0; d1_load_data = '0;
    #12;

    // Reset state
    check("rst_valid", 16'(rsp_valid), 16'h0);
    check("rst_instr", rsp_instr, 16'h0000);
    check("rst_err",   16'(rsp_err), 16'h0);
    check("rst_busy",  16'(busy), 16'h0);
    check("rst_ready", 16'(req_ready), 16'h1);
    rst_n = 1'b1;
    step();

    // Loads, then a read of 0x0002 with two-cycle latency
    do_load(16'h0000, 16'hA5A5);
    do_load(16'h0002, 16'h1234);
    do_load(16'h01FE, 16'hBEEF);
    req_valid = 1'b1; req_addr = 16'h0002;
    step();
    req_valid = 1'b0;
    check("wait_busy",  16'(busy), 16'h1);
    check("wait_ready", 16'(req_ready), 16'h0);
    check("wait_valid", 16'(rsp_valid), 16'h0);
    step();
    check("r2_valid", 16'(rsp_valid), 16'h1);
    check("r2_instr", rsp_instr, 16'h1234);
    check("r2_err",   16'(rsp_err), 16'h0);
    step();
    check("idle_valid", 16'(rsp_valid), 16'h0);
    check("idle_busy",  16'(busy), 16'h0);
    check("idle_hold",  rsp_instr, 16'h1234);

    // Reset asserted mid-WAIT drops the request
    req_valid = 1'b1; req_addr = 16'h0000;
    step();
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 16'(rsp_valid), 16'h0);
    check("midrst_busy",  16'(busy), 16'h0);
    step();
    rst_n = 1'b1;
    step();
    check("postrst_valid0", 16'(rsp_valid), 16'h0);
    step();
    check("postrst_valid1", 16'(rsp_valid), 16'h0);
    check("postrst_busy",   16'(busy), 16'h0);

    // Back-to-back: 0x0000, then 0x0002 accepted while in RESP
    req_valid = 1'b1; req_addr = 16'h0000;
    step();
    req_addr = 16'h0002;
    check("b2b_wait_ready", 16'(req_ready), 16'h0);
    step();
    check("b2b_r0_valid", 16'(rsp_valid), 16'h1);
    check("b2b_r0_instr", rsp_instr, 16'hA5A5);
    check("b2b_r0_ready", 16'(req_ready), 16'h1);
    step();
    req_valid = 1'b0;
    check("b2b_wait2_valid", 16'(rsp_valid), 16'h0);
    check("b2b_wait2_ready", 16'(req_ready), 16'h0);
    step();
    check("b2b_r1_valid", 16'(rsp_valid), 16'h1);
    check("b2b_r1_instr", rsp_instr, 16'h1234);
    step();

    // Errors and the last in-range word
    read2("mis",  16'h0003, 16'h0800, 1'b1);
    read2("oor",  16'h0200, 16'h0800, 1'b1);
    read2("last", 16'h01FE, 16'hBEEF, 1'b0);

    // Flush in WAIT: no response; the block is idle again
    req_valid = 1'b1; req_addr = 16'h0000;
    step();
    req_valid = 1'b0;
    flush = 1'b1;
    check("fw_ready", 16'(req_ready), 16'h0);
    step();
    flush = 1'b0;
    check("fw_valid0", 16'(rsp_valid), 16'h0);
    check("fw_busy",   16'(busy), 16'h0);
    step();
    check("fw_valid1", 16'(rsp_valid), 16'h0);
    read2("fw_next", 16'h0002, 16'h1234, 1'b0);

    // Flush in RESP together with a redirect request
    req_valid = 1'b1; req_addr = 16'h0000;
    step();
    req_valid = 1'b0;
    step();
    flush = 1'b1; req_valid = 1'b1; req_addr = 16'h0002;
    #1;
    check("fr_valid",  16'(rsp_valid), 16'h0);
    check("fr_ready",  16'(req_ready), 16'h1);
    step();
    flush = 1'b0; req_valid = 1'b0;
    check("fr_wait_valid", 16'(rsp_valid), 16'h0);
    step();
    check("fr_redir_valid", 16'(rsp_valid), 16'h1);
    check("fr_redir_instr", rsp_instr, 16'h1234);
    step();

    // Load hazard: overwriting an in-flight word does not change its response
    req_valid = 1'b1; req_addr = 16'h0000;
    step();
    req_valid = 1'b0;
    load_en = 1'b1; load_addr = 16'h0000; load_data = 16'hFFFF;
    step();
    load_en = 1'b0;
    check("hz_instr", rsp_instr, 16'hA5A5);
    step();
    read2("hz_after", 16'h0000, 16'hFFFF, 1'b0);

    // Same-edge load and accept to one address return the old word
    req_valid = 1'b1; req_addr = 16'h0002;
    load_en = 1'b1; load_addr = 16'h0002; load_data = 16'h5555;
    step();
    req_valid = 1'b0; load_en = 1'b0;
    step();
    check("same_edge_instr", rsp_instr, 16'h1234);
    step();
    read2("same_edge_new", 16'h0002, 16'h5555, 1'b0);

    // Out-of-range load is ignored (must not alias onto word 0)
    do_load(16'h0200, 16'h9999);
    read2("oor_load", 16'h0000, 16'hFFFF, 1'b0);

    // LATENCY=1, DEPTH=4: response on the next cycle, one per cycle sustained
    d1_do_load(16'h0000, 16'h1111);
    d1_do_load(16'h0002, 16'h2222);
    d1_req_valid = 1'b1; d1_req_addr = 16'h0000;
    step();
    d1_req_addr = 16'h0002;
    check("l1_r0_valid", 16'(d1_rsp_valid), 16'h1);
    check("l1_r0_instr", d1_rsp_instr, 16'h1111);
    check("l1_r0_ready", 16'(d1_req_ready), 16'h1);
    step();
    d1_req_addr = 16'h0008;
    check("l1_r1_valid", 16'(d1_rsp_valid), 16'h1);
    check("l1_r1_instr", d1_rsp_instr, 16'h2222);
    step();
    d1_req_valid = 1'b0;
    check("l1_r2_valid", 16'(d1_rsp_valid), 16'h1);
    check("l1_r2_instr", d1_rsp_instr, 16'h0800);
    check("l1_r2_err",   16'(d1_rsp_err), 16'h1);
    step();
    check("l1_idle_valid", 16'(d1_rsp_valid), 16'h0);
    check("l1_idle_busy",  16'(d1_busy), 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
